// File: rtl/reg_file_multi.sv
// reg_file_multi: parametrised register file with one write port and NUM_RD
// combinational read ports. It has an optional hardwired zero register and an
// optional write-to-read bypass. A built-in clear engine walks a pointer over
// every entry, one entry per cycle, after reset or when clear_req is raised in
// IDLE. While that clear runs, busy is high, reads return zero and writes are
// rejected with a wr_drop pulse.
module reg_file_multi #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear_req,
   input  logic                     Reg_write_in,
   input  logic [ADDR_W-1:0]        Write_Register,
   input  logic [DATA_W-1:0]        Write_Data,
   input  logic [NUM_RD*ADDR_W-1:0] Read_Register,
   output logic [NUM_RD*DATA_W-1:0] Read_Data,
   output logic                     busy,
   output logic                     wr_drop
);

   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   ptr_q;
   logic                wr_drop_q;
   logic                wr_drop_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                wrAccept;
   logic                wrStore;
   logic                zeroTarget;

   // A write gets through only in IDLE. It must also not collide with a clear
   // request or with reset. When the zero register is enabled, an accepted
   // write to entry 0 is swallowed silently: it does not store and it does
   // not count as a drop.
   assign wrAccept   = Reg_write_in && (state_q == IDLE) && !clear_req && !reset;
   assign zeroTarget = (ZERO_REG != 0) && (Write_Register == '0);
   assign wrStore    = wrAccept && !zeroTarget;
   assign wr_drop_d  = Reg_write_in && !wrAccept;

   assign busy    = (state_q == CLEAR);
   assign wr_drop = wr_drop_q;

   // Clear engine: reset (re)starts a full sweep from entry 0. The sweep
   // ends after the last entry is cleared. A clear request made mid-sweep is
   // ignored rather than queued.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= CLEAR;
         ptr_q     <= '0;
         wr_drop_q <= 1'b0;
      end else begin
         wr_drop_q <= wr_drop_d;
         case (state_q)
            CLEAR: begin
               ptr_q <= ptr_q + 1'b1;
               if (ptr_q == '1) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               if (clear_req) begin
                  state_q <= CLEAR;
                  ptr_q   <= '0;
               end
            end
         endcase
      end
   end

   // Storage array has no reset of its own: the clear sweep zeroes one entry
   // per cycle, and accepted writes land here only while in IDLE.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state_q == CLEAR) begin
            mem_q[ptr_q] <= '0;
         end else if (wrStore) begin
            mem_q[Write_Register] <= Write_Data;
         end
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] rdAddr;
      logic [DATA_W-1:0] rdVal;

      assign rdAddr = Read_Register[k*ADDR_W +: ADDR_W];

      // Per-port read mux, highest priority first: a sweep in progress reads
      // zero, then the zero register, then the same-cycle bypass of an
      // accepted write, and last the stored entry.
      always_comb begin
         rdVal = mem_q[rdAddr];
         if (state_q == CLEAR) begin
            rdVal = '0;
         end else if ((ZERO_REG != 0) && (rdAddr == '0)) begin
            rdVal = '0;
         end else if ((BYPASS != 0) && wrAccept && (rdAddr == Write_Register)) begin
            rdVal = Write_Data;
         end
      end

      assign Read_Data[k*DATA_W +: DATA_W] = rdVal;
   end

endmodule

// File: tb/tb_reg_file_multi.sv
// tb_reg_file_multi: drives three register-file configurations side by side:
// the default build, a build without bypass, and a narrow 8-entry build with
// three read ports and no zero register. A behavioural model keeps each file
// as a plain array plus a "clear edges remaining" count. Every cycle the
// stimulus pushes the expected outputs into a queue, and a monitor pops and
// compares them on the falling edge.
module tb_reg_file_multi;

   localparam int N = 3;

   typedef struct packed {
      logic [1:0]        dut;
      logic [15:0]       cyc;
      logic [3:0][31:0]  rd;
      logic              busy;
      logic              drop;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst [N];
   logic        clr [N];
   logic        we  [N];
   logic [4:0]  wa  [N];
   logic [31:0] wd  [N];
   logic [4:0]  ra  [N][4];

   logic [9:0]  rrA, rrB;
   logic [8:0]  rrC;
   logic [63:0] rdA, rdB;
   logic [47:0] rdC;
   logic        busyA, busyB, busyC;
   logic        dropA, dropB, dropC;

   assign rrA = {ra[0][1], ra[0][0]};
   assign rrB = {ra[1][1], ra[1][0]};
   assign rrC = {ra[2][2][2:0], ra[2][1][2:0], ra[2][0][2:0]};

   reg_file_multi dutA (
      .clk(clk), .reset(rst[0]), .clear_req(clr[0]), .Reg_write_in(we[0]),
      .Write_Register(wa[0]), .Write_Data(wd[0]), .Read_Register(rrA),
      .Read_Data(rdA), .busy(busyA), .wr_drop(dropA));

   reg_file_multi #(.BYPASS(0)) dutB (
      .clk(clk), .reset(rst[1]), .clear_req(clr[1]), .Reg_write_in(we[1]),
      .Write_Register(wa[1]), .Write_Data(wd[1]), .Read_Register(rrB),
      .Read_Data(rdB), .busy(busyB), .wr_drop(dropB));

   reg_file_multi #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3), .ZERO_REG(0)) dutC (
      .clk(clk), .reset(rst[2]), .clear_req(clr[2]), .Reg_write_in(we[2]),
      .Write_Register(wa[2][2:0]), .Write_Data(wd[2][15:0]), .Read_Register(rrC),
      .Read_Data(rdC), .busy(busyC), .wr_drop(dropC));

   int          cfgDepth  [N] = '{32, 32, 8};
   int          cfgNumRd  [N] = '{2, 2, 3};
   bit          cfgZero   [N] = '{1'b1, 1'b1, 1'b0};
   bit          cfgBypass [N] = '{1'b1, 1'b0, 1'b1};
   logic [31:0] cfgMask   [N] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF};

   logic [31:0] model     [N][32];
   int          clearLeft [N];
   bit          dropQ     [N];

   exp_t sb[$];
   int   nChecks = 0;
   int   nFails  = 0;
   int   cyc     = 0;
   bit   checkEn = 1'b0;

   function automatic void wipe(int i);
      for (int a = 0; a < 32; a++) model[i][a] = 32'h0;
   endfunction

   function automatic logic [31:0] refRead(int i, logic [4:0] a, bit acc);
      if (clearLeft[i] > 0) return 32'h0;
      if (cfgZero[i] && a == 5'd0) return 32'h0;
      if (cfgBypass[i] && acc && a == wa[i]) return wd[i] & cfgMask[i];
      return model[i][a];
   endfunction

   function automatic logic [31:0] actualRead(int i, int k);
      case (i)
         0:       return rdA[k*32 +: 32];
         1:       return rdB[k*32 +: 32];
         default: return {16'h0, rdC[k*16 +: 16]};
      endcase
   endfunction

   task automatic idleAll();
      for (int i = 0; i < N; i++) begin
         rst[i] = 1'b0; clr[i] = 1'b0; we[i] = 1'b0;
      end
   endtask

   // One cycle: record what each DUT should show now, then advance the model
   // across the coming edge and wait for it.
   task automatic applyStimulus();
      for (int i = 0; i < N; i++) begin
         bit   busyNow;
         bit   acc;
         exp_t e;
         busyNow = clearLeft[i] > 0;
         acc     = we[i] && !busyNow && !clr[i] && !rst[i];
         e       = '0;
         e.dut   = 2'(i);
         e.cyc   = 16'(cyc);
         e.busy  = busyNow;
         e.drop  = dropQ[i];
         for (int k = 0; k < cfgNumRd[i]; k++) e.rd[k] = refRead(i, ra[i][k], acc);
         if (checkEn) sb.push_back(e);
         if (rst[i]) begin
            clearLeft[i] = cfgDepth[i];
            dropQ[i]     = 1'b0;
            wipe(i);
         end else if (busyNow) begin
            clearLeft[i] = clearLeft[i] - 1;
            dropQ[i]     = we[i];
         end else begin
            dropQ[i] = we[i] && !acc;
            if (acc && !(cfgZero[i] && wa[i] == 5'd0)) model[i][wa[i]] = wd[i] & cfgMask[i];
            if (clr[i]) begin
               clearLeft[i] = cfgDepth[i];
               wipe(i);
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic runIdle(int n);
      for (int c = 0; c < n; c++) begin
         idleAll();
         applyStimulus();
      end
   endtask

   task automatic compareOne(string name, int d, int c, logic [31:0] got, logic [31:0] want);
      nChecks++;
      if (got !== want) begin
         nFails++;
         $display("[TB] FAIL %s dut%0d cyc%0d: got %h, expected %h", name, d, c, got, want);
      end
   endtask

   task automatic checkOutput(exp_t e);
      int   d;
      logic b, dr;
      d  = int'(e.dut);
      b  = (d == 0) ? busyA : (d == 1) ? busyB : busyC;
      dr = (d == 0) ? dropA : (d == 1) ? dropB : dropC;
      compareOne("busy", d, int'(e.cyc), {31'h0, b}, {31'h0, e.busy});
      compareOne("wr_drop", d, int'(e.cyc), {31'h0, dr}, {31'h0, e.drop});
      for (int k = 0; k < cfgNumRd[d]; k++)
         compareOne($sformatf("read_port%0d", k), d, int'(e.cyc), actualRead(d, k), e.rd[k]);
   endtask

   // Monitor: consume every expectation queued during this cycle.
   initial begin
      forever begin
         @(negedge clk);
         while (sb.size() > 0) checkOutput(sb.pop_front());
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         wa[i] = 5'd0; wd[i] = 32'h0;
         for (int k = 0; k < 4; k++) ra[i][k] = 5'(k + 1);
         clearLeft[i] = 0; dropQ[i] = 1'b0; wipe(i);
      end
      idleAll();

      // Reset held for two edges, then the post-reset sweep.
      for (int i = 0; i < N; i++) rst[i] = 1'b1;
      applyStimulus();
      checkEn = 1'b1;
      for (int i = 0; i < N; i++) rst[i] = 1'b1;
      applyStimulus();
      runIdle(34);

      // Basic writes and reads, plus a write into the zero register.
      idleAll(); we[0] = 1; wa[0] = 5'd2; wd[0] = 32'h0000_000F;
      we[1] = 1; wa[1] = 5'd2; wd[1] = 32'h0000_000F; applyStimulus();
      idleAll(); we[0] = 1; wa[0] = 5'd4; wd[0] = 32'h0000_0015;
      we[1] = 1; wa[1] = 5'd4; wd[1] = 32'h0000_0015; applyStimulus();
      ra[0][0] = 5'd2; ra[0][1] = 5'd4; ra[1][0] = 5'd2; ra[1][1] = 5'd4;
      runIdle(1);
      idleAll(); we[0] = 1; wa[0] = 5'd0; wd[0] = 32'hDEAD_BEEF; ra[0][0] = 5'd0; applyStimulus();
      runIdle(2);

      // Bypass versus no bypass on entry 31, with an older value stored first.
      idleAll(); we[0] = 1; wa[0] = 5'd31; wd[0] = 32'h11;
      we[1] = 1; wa[1] = 5'd31; wd[1] = 32'h11; applyStimulus();
      ra[0][0] = 5'd31; ra[1][0] = 5'd31;
      idleAll(); we[0] = 1; wa[0] = 5'd31; wd[0] = 32'h4C;
      we[1] = 1; wa[1] = 5'd31; wd[1] = 32'h4C; applyStimulus();
      runIdle(1);

      // Clear request colliding with a write, then a clear_req pulse mid-sweep.
      ra[0][0] = 5'd25;
      idleAll(); we[0] = 1; wa[0] = 5'd25; wd[0] = 32'h8; clr[0] = 1; applyStimulus();
      runIdle(10);
      idleAll(); clr[0] = 1; applyStimulus();
      runIdle(24);

      // Reset on the tenth edge of a sweep, and a write attempted while busy.
      idleAll(); we[0] = 1; wa[0] = 5'd9; wd[0] = 32'h77; applyStimulus();
      ra[0][1] = 5'd9;
      idleAll(); clr[0] = 1; applyStimulus();
      runIdle(8);
      idleAll(); rst[0] = 1; applyStimulus();
      idleAll(); we[0] = 1; wa[0] = 5'd9; wd[0] = 32'h99; applyStimulus();
      runIdle(33);

      // Narrow build: entry 0 is writable here, three ports share an entry.
      idleAll(); we[2] = 1; wa[2] = 5'd0; wd[2] = 32'h0000_A5A5; applyStimulus();
      idleAll(); we[2] = 1; wa[2] = 5'd7; wd[2] = 32'h0000_A5A5; applyStimulus();
      ra[2][0] = 5'd0; ra[2][1] = 5'd7; ra[2][2] = 5'd7;
      runIdle(1);
      idleAll(); rst[2] = 1; applyStimulus();
      runIdle(10);

      // Randomised traffic on all three builds.
      for (int c = 0; c < 500; c++) begin
         idleAll();
         for (int i = 0; i < N; i++) begin
            rst[i] = ($urandom_range(0, 149) == 0);
            clr[i] = ($urandom_range(0, 59) == 0);
            we[i]  = ($urandom_range(0, 1) == 1);
            wa[i]  = 5'($urandom_range(0, cfgDepth[i] - 1));
            wd[i]  = $urandom;
            for (int k = 0; k < 4; k++)
               ra[i][k] = ($urandom_range(0, 3) == 0) ? wa[i] : 5'($urandom_range(0, cfgDepth[i] - 1));
         end
         applyStimulus();
      end
      runIdle(2);

      @(negedge clk);
      #1;
      nChecks++;
      if (sb.size() != 0) begin
         nFails++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/reg_file_multi.md
Name: reg_file_multi

Overview:
- Parametrised register file for the datapath: one write port, NUM_RD combinational read ports.
- Optional hardwired zero register and optional write-to-read bypass.
- Built-in clear engine zeroes every entry, one per cycle, after reset or on request; busy is flagged throughout.
- Drops into the decode stage in place of the fixed 32x32, two-read-port file.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes
- BYPASS, 1, 1 = an accepted same-cycle write is forwarded to matching read ports

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- clear_req  in  1  start a full clear (sampled in IDLE only)
- Reg_write_in  in  1  write enable
- Write_Register  in  ADDR_W  write address
- Write_Data  in  DATA_W  write data
- Read_Register  in  NUM_RD*ADDR_W  packed read addresses; port k = bits [k*ADDR_W +: ADDR_W]
- Read_Data  out  NUM_RD*DATA_W  packed read data; port k = bits [k*DATA_W +: DATA_W]
- busy  out  1  clear engine active
- wr_drop  out  1  registered one-cycle pulse: a write was rejected

Behaviour:
- One clock, synchronous active-high reset. Storage is DEPTH x DATA_W flops; there is no reset on the array itself.

FSM states: IDLE, CLEAR. Internal clear pointer ptr is ADDR_W bits wide.
- Edge with reset=1: state<=CLEAR, ptr<=0, wr_drop<=0. No array write.
- CLEAR, each edge with reset=0: mem[ptr]<=0 and ptr<=ptr+1. When ptr==DEPTH-1, state<=IDLE.
- A clear therefore takes exactly DEPTH edges.
- IDLE with clear_req=1: state<=CLEAR, ptr<=0.
- clear_req during CLEAR is ignored. There is no restart and no queuing.
- reset asserted mid-clear restarts the clear from ptr=0.

busy:
- busy = (state==CLEAR), decoded combinationally from the state register.
- busy is therefore 1 from the edge after reset is sampled until the DEPTH-th clearing edge.

Write acceptance:
- A write is accepted iff Reg_write_in=1, state==IDLE, clear_req=0 and reset=0.
- An accepted write sets mem[Write_Register]<=Write_Data on the edge.
- With ZERO_REG=1 and Write_Register==0, the write is ignored silently. It is not a drop.
- If Reg_write_in=1 but the write is not accepted for any reason other than the zero register: wr_drop<=1 on that edge.
- Otherwise wr_drop<=0.

Reads (combinational, per port k; priority top to bottom):
1. state==CLEAR -> 0.
2. ZERO_REG=1 and address==0 -> 0.
3. BYPASS=1, write accepted this cycle and address==Write_Register -> Write_Data.
4. Otherwise -> mem[address].
- With BYPASS=0, the new value is visible only after the write edge.
- Multiple read ports may address the same entry. Each port returns identical data.
- Widths: there is no arithmetic on data. The ptr wrap is prevented by the IDLE transition at DEPTH-1.

Test Plan:
1. Defaults; reset high for 2 edges, then low. Expect busy=1 for exactly 32 edges, then 0. Both read ports return 0 throughout and after.
2. After the clear, write 0x0000_000F to reg 2 and 0x0000_0015 to reg 4. Set Read_Register = {4,2}. Expect Read_Data = {0x15, 0x0F}. A write of 0xDEADBEEF to reg 0 followed by a read of reg 0 returns 0, with wr_drop=0.
3. Bypass: in the same cycle, write 0x4C to reg 31 with port 0 reading 31. Port 0 shows 0x4C before the edge. Repeat with BYPASS=0: port 0 shows the old value before the edge and 0x4C after it.
4. Clear collision: in IDLE, assert clear_req and Reg_write_in (reg 25, 0x8) together. Expect a wr_drop pulse for 1 cycle, busy=1 for 32 edges, and reg 25 reads 0 afterwards. clear_req pulsed mid-clear does not extend busy.
5. Reset mid-operation: assert reset at edge 10 of a clear. Expect busy to stay high for a further 32 edges after reset drops. A write attempted during busy pulses wr_drop and the entry remains 0.
6. Generics: DATA_W=16, ADDR_W=3, NUM_RD=3, ZERO_REG=0. Write 0xA5A5 to reg 0 and reg 7. All three ports reading {0,7,7} return {0xA5A5,0xA5A5,0xA5A5}. A reset-triggered clear lasts 8 edges.
